// File: rtl/pcs_pkg.sv
// Shared 10GBASE-R receive PCS definitions: sync header encodings, lock FSM
// states and the header validity test.
package pcs_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  typedef enum logic [1:0] {
    ST_TEST   = 2'd0,
    ST_SLIP   = 2'd1,
    ST_LOCKED = 2'd2
  } lock_state_t;

  function automatic logic is_valid_hdr(input logic [1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/pcs_sat_counter.sv
// Saturating statistics counter; a clear takes priority over an increment.
module pcs_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             rx_clk,
  input  logic             rx_rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pcs_rx_block_lock_ctrl.sv
// 10GBASE-R receive block-lock controller: slips the SERDES until sync headers
// align, declares lock, and drops it when too many headers go bad in a window.
module pcs_rx_block_lock_ctrl
  import pcs_pkg::*;
#(
  parameter int HDR_WIDTH           = 2,
  parameter int SH_CNT_MAX          = 64,
  parameter int SH_INVLD_MAX        = 16,
  parameter int BITSLIP_HIGH_CYCLES = 1,
  parameter int BITSLIP_LOW_CYCLES  = 8,
  parameter int CNT_WIDTH           = 16
) (
  input  logic                 rx_clk,
  input  logic                 rx_rst,
  input  logic [HDR_WIDTH-1:0] serdes_rx_hdr,
  input  logic                 serdes_rx_hdr_valid,
  input  logic                 cfg_cnt_clear,
  output logic                 serdes_rx_bitslip,
  output logic                 rx_block_lock,
  output logic                 rx_sh_invalid,
  output logic [CNT_WIDTH-1:0] rx_invalid_hdr_count,
  output logic [CNT_WIDTH-1:0] rx_slip_count
);

  if (HDR_WIDTH != 2) begin : g_bad_hdr_width
    $error("pcs_rx_block_lock_ctrl: HDR_WIDTH must be 2");
  end

  localparam int SH_CNT_W = $clog2(SH_CNT_MAX + 1);
  localparam int INVLD_W  = $clog2(SH_INVLD_MAX + 1);
  localparam int TMR_W    = $clog2(BITSLIP_HIGH_CYCLES + BITSLIP_LOW_CYCLES + 1);

  localparam logic [SH_CNT_W-1:0] SH_CNT_LAST = SH_CNT_W'(SH_CNT_MAX - 1);
  localparam logic [INVLD_W-1:0]  INVLD_LAST  = INVLD_W'(SH_INVLD_MAX - 1);
  localparam logic [TMR_W-1:0]    TMR_LAST    =
    TMR_W'(BITSLIP_HIGH_CYCLES + BITSLIP_LOW_CYCLES - 1);
  localparam logic [TMR_W-1:0]    TMR_HIGH    = TMR_W'(BITSLIP_HIGH_CYCLES);

  lock_state_t         state_q, state_d;
  logic [SH_CNT_W-1:0] sh_cnt_q, sh_cnt_d;
  logic [INVLD_W-1:0]  invld_q, invld_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;

  logic hdr_qualified;
  logic hdr_ok;

  logic bitslip_d, lock_d, sh_invalid_d, slip_inc;
  logic bitslip_p1, lock_p1, sh_invalid_p1;

  // Headers only count while testing or locked; the settle window ignores them.
  assign hdr_qualified = serdes_rx_hdr_valid &&
                         ((state_q == ST_TEST) || (state_q == ST_LOCKED));
  assign hdr_ok        = is_valid_hdr(serdes_rx_hdr);

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      state_q  <= ST_TEST;
      sh_cnt_q <= '0;
      invld_q  <= '0;
      tmr_q    <= '0;
    end else begin
      state_q  <= state_d;
      sh_cnt_q <= sh_cnt_d;
      invld_q  <= invld_d;
      tmr_q    <= tmr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sh_cnt_d = sh_cnt_q;
    invld_d  = invld_q;
    tmr_d    = tmr_q;
    case (state_q)
      ST_TEST: begin
        tmr_d = '0;
        if (hdr_qualified) begin
          if (!hdr_ok) begin
            state_d  = ST_SLIP;
            sh_cnt_d = '0;
            invld_d  = '0;
          end else if (sh_cnt_q == SH_CNT_LAST) begin
            state_d  = ST_LOCKED;
            sh_cnt_d = '0;
            invld_d  = '0;
          end else begin
            sh_cnt_d = sh_cnt_q + 1'b1;
          end
        end
      end
      ST_SLIP: begin
        sh_cnt_d = '0;
        invld_d  = '0;
        if (tmr_q == TMR_LAST) begin
          state_d = ST_TEST;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_LOCKED: begin
        // Threshold hit beats window end when both land on the same header.
        if (hdr_qualified) begin
          if (!hdr_ok && (invld_q == INVLD_LAST)) begin
            state_d  = ST_SLIP;
            sh_cnt_d = '0;
            invld_d  = '0;
            tmr_d    = '0;
          end else if (sh_cnt_q == SH_CNT_LAST) begin
            sh_cnt_d = '0;
            invld_d  = '0;
          end else begin
            sh_cnt_d = sh_cnt_q + 1'b1;
            if (!hdr_ok) begin
              invld_d = invld_q + 1'b1;
            end
          end
        end
      end
      default: begin
        state_d  = ST_TEST;
        sh_cnt_d = '0;
        invld_d  = '0;
        tmr_d    = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register one cycle after the header.
  always_comb begin
    bitslip_d    = (state_d == ST_SLIP) && (tmr_d < TMR_HIGH);
    lock_d       = (state_d == ST_LOCKED);
    sh_invalid_d = hdr_qualified && !hdr_ok;
    slip_inc     = (state_d == ST_SLIP) && (state_q != ST_SLIP);
  end

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      bitslip_p1    <= 1'b0;
      lock_p1       <= 1'b0;
      sh_invalid_p1 <= 1'b0;
    end else begin
      bitslip_p1    <= bitslip_d;
      lock_p1       <= lock_d;
      sh_invalid_p1 <= sh_invalid_d;
    end
  end

  assign serdes_rx_bitslip = bitslip_p1;
  assign rx_block_lock     = lock_p1;
  assign rx_sh_invalid     = sh_invalid_p1;

  pcs_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_invalid_cnt (
    .rx_clk (rx_clk),
    .rx_rst (rx_rst),
    .inc    (sh_invalid_d),
    .clr    (cfg_cnt_clear),
    .count  (rx_invalid_hdr_count)
  );

  pcs_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_slip_cnt (
    .rx_clk (rx_clk),
    .rx_rst (rx_rst),
    .inc    (slip_inc),
    .clr    (cfg_cnt_clear),
    .count  (rx_slip_count)
  );

endmodule

// File: tb/tb_pcs_rx_block_lock_ctrl.sv
// Directed bench for pcs_rx_block_lock_ctrl with default parameters.
module tb_pcs_rx_block_lock_ctrl;

  logic        rx_clk = 1'b0;
  logic        rx_rst = 1'b1;
  logic [1:0]  serdes_rx_hdr = 2'b00;
  logic        serdes_rx_hdr_valid = 1'b0;
  logic        cfg_cnt_clear = 1'b0;
  logic        serdes_rx_bitslip;
  logic        rx_block_lock;
  logic        rx_sh_invalid;
  logic [15:0] rx_invalid_hdr_count;
  logic [15:0] rx_slip_count;

  int checks = 0;
  int errors = 0;

  always #5 rx_clk = ~rx_clk;

  pcs_rx_block_lock_ctrl dut (
    .rx_clk               (rx_clk),
    .rx_rst               (rx_rst),
    .serdes_rx_hdr        (serdes_rx_hdr),
    .serdes_rx_hdr_valid  (serdes_rx_hdr_valid),
    .cfg_cnt_clear        (cfg_cnt_clear),
    .serdes_rx_bitslip    (serdes_rx_bitslip),
    .rx_block_lock        (rx_block_lock),
    .rx_sh_invalid        (rx_sh_invalid),
    .rx_invalid_hdr_count (rx_invalid_hdr_count),
    .rx_slip_count        (rx_slip_count)
  );

  task automatic tick();
    @(posedge rx_clk);
    #1;
  endtask

  task automatic do_reset();
    rx_rst = 1'b1;
    serdes_rx_hdr = 2'b00;
    serdes_rx_hdr_valid = 1'b0;
    cfg_cnt_clear = 1'b0;
    repeat (2) @(posedge rx_clk);
    #1 rx_rst = 1'b0;
  endtask

  task automatic lock_up();
    for (int i = 0; i < 64; i++) begin
      serdes_rx_hdr = 2'b01;
      serdes_rx_hdr_valid = 1'b1;
      tick();
    end
    serdes_rx_hdr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rx_rst = 1'b1;
    serdes_rx_hdr = 2'b11;
    serdes_rx_hdr_valid = 1'b1;
    repeat (3) tick();
    checks++;
    if (serdes_rx_bitslip !== 1'b0 || rx_block_lock !== 1'b0 || rx_sh_invalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: bitslip=%b lock=%b sh_invalid=%b required 0 0 0",
               serdes_rx_bitslip, rx_block_lock, rx_sh_invalid);
    end
    checks++;
    if (rx_invalid_hdr_count !== 16'h0 || rx_slip_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_counts: invalid=%h slip=%h required 0000 0000",
               rx_invalid_hdr_count, rx_slip_count);
    end
    do_reset();
  endtask

  task automatic test_lock();
    int early = 0;
    int slips = 0;
    do_reset();
    for (int i = 0; i < 64; i++) begin
      serdes_rx_hdr = 2'b01;
      serdes_rx_hdr_valid = 1'b1;
      tick();
      if (serdes_rx_bitslip !== 1'b0) slips++;
      if (i < 63 && rx_block_lock !== 1'b0) early++;
    end
    serdes_rx_hdr_valid = 1'b0;
    checks++;
    if (early !== 0) begin
      errors++;
      $display("FAIL lock_early: %0d cycles locked before 64th header, required 0", early);
    end
    checks++;
    if (rx_block_lock !== 1'b1) begin
      errors++;
      $display("FAIL lock_after_64: lock=%b required 1", rx_block_lock);
    end
    checks++;
    if (slips !== 0) begin
      errors++;
      $display("FAIL lock_no_bitslip: %0d bitslip cycles, required 0", slips);
    end
    checks++;
    if (rx_invalid_hdr_count !== 16'h0 || rx_slip_count !== 16'h0) begin
      errors++;
      $display("FAIL lock_counts: invalid=%h slip=%h required 0000 0000",
               rx_invalid_hdr_count, rx_slip_count);
    end
  endtask

  task automatic test_slip_cycle();
    int bs_err = 0;
    int inv_err = 0;
    int lock_err = 0;
    logic exp_pulse;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      serdes_rx_hdr = (((i / 5) % 2) != 0) ? 2'b11 : 2'b00;
      serdes_rx_hdr_valid = 1'b1;
      tick();
      exp_pulse = ((i % 10) == 0);
      if (serdes_rx_bitslip !== exp_pulse) bs_err++;
      if (rx_sh_invalid !== exp_pulse) inv_err++;
      if (rx_block_lock !== 1'b0) lock_err++;
    end
    serdes_rx_hdr_valid = 1'b0;
    checks++;
    if (bs_err !== 0) begin
      errors++;
      $display("FAIL slip_pulse_timing: %0d cycles wrong, required 0", bs_err);
    end
    checks++;
    if (inv_err !== 0) begin
      errors++;
      $display("FAIL slip_sh_invalid_timing: %0d cycles wrong, required 0", inv_err);
    end
    checks++;
    if (lock_err !== 0) begin
      errors++;
      $display("FAIL slip_lock_low: %0d cycles locked, required 0", lock_err);
    end
    checks++;
    if (rx_slip_count !== 16'd30) begin
      errors++;
      $display("FAIL slip_count: got %0d required 30", rx_slip_count);
    end
    checks++;
    if (rx_invalid_hdr_count !== 16'd30) begin
      errors++;
      $display("FAIL slip_invalid_count: got %0d required 30", rx_invalid_hdr_count);
    end
  endtask

  task automatic test_window();
    int lock_err = 0;
    do_reset();
    lock_up();
    for (int i = 0; i < 64; i++) begin
      serdes_rx_hdr = (i < 15) ? 2'b11 : 2'b01;
      serdes_rx_hdr_valid = 1'b1;
      tick();
      if (rx_block_lock !== 1'b1) lock_err++;
    end
    checks++;
    if (lock_err !== 0 || rx_invalid_hdr_count !== 16'd15 || rx_slip_count !== 16'd0) begin
      errors++;
      $display("FAIL window_15_held: unlocked=%0d invalid=%0d slip=%0d required 0 15 0",
               lock_err, rx_invalid_hdr_count, rx_slip_count);
    end
    lock_err = 0;
    for (int i = 0; i < 16; i++) begin
      serdes_rx_hdr = 2'b11;
      serdes_rx_hdr_valid = 1'b1;
      tick();
      if (i < 15 && rx_block_lock !== 1'b1) lock_err++;
    end
    serdes_rx_hdr_valid = 1'b0;
    checks++;
    if (lock_err !== 0) begin
      errors++;
      $display("FAIL window_16_early_drop: %0d cycles unlocked before 16th, required 0", lock_err);
    end
    checks++;
    if (rx_block_lock !== 1'b0 || serdes_rx_bitslip !== 1'b1) begin
      errors++;
      $display("FAIL window_16_drop: lock=%b bitslip=%b required 0 1",
               rx_block_lock, serdes_rx_bitslip);
    end
    checks++;
    if (rx_invalid_hdr_count !== 16'd31 || rx_slip_count !== 16'd1) begin
      errors++;
      $display("FAIL window_16_counts: invalid=%0d slip=%0d required 31 1",
               rx_invalid_hdr_count, rx_slip_count);
    end
    tick();
    checks++;
    if (serdes_rx_bitslip !== 1'b0) begin
      errors++;
      $display("FAIL window_pulse_width: bitslip=%b required 0", serdes_rx_bitslip);
    end
  endtask

  task automatic test_hdr_valid_gate();
    int bad = 0;
    do_reset();
    serdes_rx_hdr = 2'b11;
    serdes_rx_hdr_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (serdes_rx_bitslip !== 1'b0 || rx_sh_invalid !== 1'b0) bad++;
    end
    lock_up();
    serdes_rx_hdr = 2'b11;
    serdes_rx_hdr_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (serdes_rx_bitslip !== 1'b0 || rx_sh_invalid !== 1'b0 || rx_block_lock !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL gate_outputs: %0d cycles reacted to unqualified header, required 0", bad);
    end
    checks++;
    if (rx_invalid_hdr_count !== 16'h0 || rx_slip_count !== 16'h0) begin
      errors++;
      $display("FAIL gate_counts: invalid=%h slip=%h required 0000 0000",
               rx_invalid_hdr_count, rx_slip_count);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    @(negedge rx_clk);
    force dut.u_invalid_cnt.count = 16'hFFFE;
    @(negedge rx_clk);
    release dut.u_invalid_cnt.count;
    checks++;
    if (rx_invalid_hdr_count !== 16'hFFFE) begin
      errors++;
      $display("FAIL sat_preload: got %h required fffe", rx_invalid_hdr_count);
    end
    serdes_rx_hdr = 2'b11;
    serdes_rx_hdr_valid = 1'b1;
    tick();
    checks++;
    if (rx_invalid_hdr_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_first_inc: got %h required ffff", rx_invalid_hdr_count);
    end
    repeat (29) tick();
    checks++;
    if (rx_invalid_hdr_count !== 16'hFFFF || rx_slip_count !== 16'd3) begin
      errors++;
      $display("FAIL sat_hold: invalid=%h slip=%0d required ffff 3",
               rx_invalid_hdr_count, rx_slip_count);
    end
    cfg_cnt_clear = 1'b1;
    tick();
    cfg_cnt_clear = 1'b0;
    serdes_rx_hdr_valid = 1'b0;
    checks++;
    if (rx_invalid_hdr_count !== 16'h0 || rx_slip_count !== 16'h0 || rx_sh_invalid !== 1'b1) begin
      errors++;
      $display("FAIL sat_clear_wins: invalid=%h slip=%h sh_invalid=%b required 0000 0000 1",
               rx_invalid_hdr_count, rx_slip_count, rx_sh_invalid);
    end
  endtask

  task automatic test_async_reset();
    int early = 0;
    do_reset();
    serdes_rx_hdr = 2'b11;
    serdes_rx_hdr_valid = 1'b1;
    tick();
    serdes_rx_hdr_valid = 1'b0;
    checks++;
    if (serdes_rx_bitslip !== 1'b1) begin
      errors++;
      $display("FAIL arst_pulse_start: bitslip=%b required 1", serdes_rx_bitslip);
    end
    #2 rx_rst = 1'b1;
    #1;
    checks++;
    if (serdes_rx_bitslip !== 1'b0 || rx_slip_count !== 16'h0) begin
      errors++;
      $display("FAIL arst_bitslip_drop: bitslip=%b slip=%0d required 0 0",
               serdes_rx_bitslip, rx_slip_count);
    end
    @(negedge rx_clk);
    rx_rst = 1'b0;
    lock_up();
    checks++;
    if (rx_block_lock !== 1'b1) begin
      errors++;
      $display("FAIL arst_prelock: lock=%b required 1", rx_block_lock);
    end
    #2 rx_rst = 1'b1;
    #1;
    checks++;
    if (rx_block_lock !== 1'b0) begin
      errors++;
      $display("FAIL arst_lock_drop: lock=%b required 0", rx_block_lock);
    end
    @(negedge rx_clk);
    rx_rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      serdes_rx_hdr = 2'b01;
      serdes_rx_hdr_valid = 1'b1;
      tick();
      if (i < 63 && rx_block_lock !== 1'b0) early++;
    end
    serdes_rx_hdr_valid = 1'b0;
    checks++;
    if (early !== 0 || rx_block_lock !== 1'b1) begin
      errors++;
      $display("FAIL arst_relock: early=%0d lock=%b required 0 1", early, rx_block_lock);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_slip_cycle();
    test_window();
    test_hdr_valid_gate();
    test_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pcs_rx_block_lock_ctrl.md
Name: pcs_rx_block_lock_ctrl

Overview:
Parametrised 10GBASE-R receive block-lock controller, per IEEE 802.3 Clause 49.2.13.
- Inspects every 2-bit sync header from the SERDES/gearbox.
- Drives the bitslip request until headers align, then declares block lock.
- Holds lock until the invalid-header threshold is exceeded within a window.
- Next generation of the rx frame-sync logic: thresholds, slip timing and a header-valid qualifier are all configurable, and saturating invalid-header and slip counters support the invalid-sync-header regression benches.

Parameters:
- HDR_WIDTH, 2, sync header width; fixed at 2 and checked by elaboration assertion.
- SH_CNT_MAX, 64, headers per test window.
- SH_INVLD_MAX, 16, invalid headers within one window that drop lock.
- BITSLIP_HIGH_CYCLES, 1, cycles serdes_rx_bitslip is held high per slip.
- BITSLIP_LOW_CYCLES, 8, settle cycles after a slip; headers are ignored during these cycles.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- rx_clk  in  1  receive clock.
- rx_rst  in  1  reset, asynchronous, active-high.
- serdes_rx_hdr  in  HDR_WIDTH  sync header of the current block.
- serdes_rx_hdr_valid  in  1  header qualifier from the gearbox; when 0 the cycle is ignored.
- cfg_cnt_clear  in  1  synchronous clear of both statistics counters.
- serdes_rx_bitslip  out  1  bitslip request to the SERDES.
- rx_block_lock  out  1  block lock status.
- rx_sh_invalid  out  1  one-cycle pulse for each qualified invalid header.
- rx_invalid_hdr_count  out  CNT_WIDTH  saturating count of invalid headers.
- rx_slip_count  out  CNT_WIDTH  saturating count of slips issued.

Behaviour:
- Valid header = 2'b01 or 2'b10. Invalid = 2'b00 or 2'b11. A header is qualified when serdes_rx_hdr_valid=1 and the FSM is in TEST or LOCKED.
- Reset values: all outputs 0, FSM=TEST, sh_cnt=0, sh_invld_cnt=0.
- All outputs are registered. Latency is 1 cycle from the qualified header to any output change.
- rx_sh_invalid: asserted the cycle after any qualified invalid header, in both TEST and LOCKED.
- FSM TEST (unlocked):
  - Qualified valid header: sh_cnt++.
  - When the SH_CNT_MAX-th consecutive valid header is seen -> LOCKED. rx_block_lock=1 on the next cycle; counters cleared.
  - Any qualified invalid header -> SLIP; counters cleared.
- FSM SLIP:
  - serdes_rx_bitslip=1 for BITSLIP_HIGH_CYCLES cycles.
  - Then 0 for BITSLIP_LOW_CYCLES cycles; headers are ignored and serdes_rx_hdr_valid is don't-care.
  - Then -> TEST.
  - rx_slip_count increments once per entry to SLIP.
  - With continuous invalid headers the slip period is exactly 1+BITSLIP_HIGH_CYCLES+BITSLIP_LOW_CYCLES cycles (10 with defaults).
- FSM LOCKED:
  - Every qualified header: sh_cnt++. Invalid headers also increment sh_invld_cnt.
  - If sh_invld_cnt reaches SH_INVLD_MAX -> SLIP; rx_block_lock=0 on the next cycle. This check takes priority over window end when both occur on the same header.
  - Otherwise, when sh_cnt reaches SH_CNT_MAX: clear both counters and stay LOCKED.
- rx_block_lock is 1 only in LOCKED.
- Counters: rx_invalid_hdr_count and rx_slip_count saturate at all-ones and never wrap.
  - cfg_cnt_clear zeroes both on the next edge.
  - If cfg_cnt_clear coincides with an increment, the clear wins and the result is 0.
  - The counters are not cleared by an FSM lock change.
- rx_rst asserted mid-operation: all state and outputs go to 0 immediately (asynchronous). This includes a bitslip pulse in progress, which is truncated. After release, operation restarts in TEST.
- Counter widths:
  - sh_cnt: $clog2(SH_CNT_MAX+1) bits.
  - sh_invld_cnt: $clog2(SH_INVLD_MAX+1) bits.
  - slip timer: $clog2(BITSLIP_HIGH_CYCLES+BITSLIP_LOW_CYCLES+1) bits.

Decomposition:
- Shared package pcs_pkg holds:
  - SYNC_DATA=2'b01 and SYNC_CTRL=2'b10;
  - the FSM state enum {ST_TEST, ST_SLIP, ST_LOCKED};
  - an is_valid_hdr function.
- One natural sub-module: pcs_sat_counter (width parameter; inc, clr, count out), instantiated twice for the statistics counters.

Test Plan:
- Reset, then 64 consecutive 2'b01 headers with valid=1 -> rx_block_lock=1 exactly one cycle after the 64th header; serdes_rx_bitslip never asserted; both counts 0.
- Headers alternating 2'b00/2'b11 every 5 cycles for 300 cycles -> rx_block_lock stays 0; bitslip pulses 1 cycle wide every 10 cycles; rx_slip_count=30; rx_invalid_hdr_count=30.
- Locked, then 15 invalid headers in a 64-header window -> lock held, rx_invalid_hdr_count=15. Next window with 16 invalid headers -> rx_block_lock=0 the cycle after the 16th invalid header, followed by a bitslip pulse.
- serdes_rx_hdr_valid=0 while 2'b11 is driven -> no rx_sh_invalid, no slip, counters unchanged.
- Force rx_invalid_hdr_count to 16'hFFFE and inject 3 invalid headers -> count stays at 16'hFFFF. Assert cfg_cnt_clear together with an invalid header -> count=0.
- rx_rst asserted mid-bitslip-pulse and while locked -> serdes_rx_bitslip and rx_block_lock drop without waiting for a clock edge. After release, 64 valid headers re-lock.
